// File: rtl/tcu_uop_sequencer_pkg.sv
// ============================================================================
// Module   : tcu_uop_sequencer_pkg
// Brief    : Shared TCU constants, op encodings and the uop record type.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tcu_uop_sequencer_pkg;

    localparam int TCU_M_STEPS = 2;
    localparam int TCU_N_STEPS = 4;
    localparam int TCU_K_STEPS = 4;

    localparam int TCU_RA    = 0;
    localparam int TCU_RB    = 8;
    localparam int TCU_RC    = 24;
    localparam int TCU_REG_W = 5;

    typedef enum logic [1:0] {
        TCU_OP_WMMA         = 2'd0,
        TCU_OP_SP_WMMA      = 2'd1,
        TCU_OP_SP_MV_FORMAT = 2'd2,
        TCU_OP_RSVD         = 2'd3
    } tcu_op_e;

    // Step index width; a single-step dimension still gets one bit.
    function automatic int tcu_clog2_min1(input int value);
        int w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

    localparam int TCU_STEP_M_W = tcu_clog2_min1(TCU_M_STEPS);
    localparam int TCU_STEP_N_W = tcu_clog2_min1(TCU_N_STEPS);
    localparam int TCU_STEP_K_W = tcu_clog2_min1(TCU_K_STEPS);

    typedef struct packed {
        logic [TCU_STEP_M_W-1:0] step_m;
        logic [TCU_STEP_N_W-1:0] step_n;
        logic [TCU_STEP_K_W-1:0] step_k;
        logic [TCU_REG_W-1:0]    ra;
        logic [TCU_REG_W-1:0]    rb;
        logic [TCU_REG_W-1:0]    rc;
        logic                    meta_sel;
        logic                    last;
    } tcu_uop_t;

endpackage

`default_nettype wire

// File: rtl/tcu_step_counter.sv
// ============================================================================
// Module   : tcu_step_counter
// Brief    : Three-level nested wrap counter (n inner, m middle, k outer).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tcu_step_counter
    import tcu_uop_sequencer_pkg::*;
#(
    parameter int M_STEPS = TCU_M_STEPS,
    parameter int N_STEPS = TCU_N_STEPS,
    parameter int K_STEPS = TCU_K_STEPS,
    parameter int MW      = tcu_clog2_min1(M_STEPS),
    parameter int NW      = tcu_clog2_min1(N_STEPS),
    parameter int KW      = tcu_clog2_min1(K_STEPS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [MW-1:0] step_m,
    output logic [NW-1:0] step_n,
    output logic [KW-1:0] step_k,
    output logic [MW-1:0] next_m,
    output logic [NW-1:0] next_n,
    output logic [KW-1:0] next_k,
    output logic          last_next
);

    localparam logic [MW-1:0] M_MAX = MW'(M_STEPS - 1);
    localparam logic [NW-1:0] N_MAX = NW'(N_STEPS - 1);
    localparam logic [KW-1:0] K_MAX = KW'(K_STEPS - 1);

    logic [MW-1:0] m_q, m_d;
    logic [NW-1:0] n_q, n_d;
    logic [KW-1:0] k_q, k_d;

    always_comb begin
        m_d = m_q;
        n_d = n_q;
        k_d = k_q;
        if (clr) begin
            m_d = '0;
            n_d = '0;
            k_d = '0;
        end else if (en) begin
            if (n_q == N_MAX) begin
                n_d = '0;
                if (m_q == M_MAX) begin
                    m_d = '0;
                    k_d = (k_q == K_MAX) ? '0 : k_q + 1'b1;
                end else begin
                    m_d = m_q + 1'b1;
                end
            end else begin
                n_d = n_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_q <= '0;
            n_q <= '0;
            k_q <= '0;
        end else begin
            m_q <= m_d;
            n_q <= n_d;
            k_q <= k_d;
        end
    end

    assign step_m    = m_q;
    assign step_n    = n_q;
    assign step_k    = k_q;
    assign next_m    = m_d;
    assign next_n    = n_d;
    assign next_k    = k_d;
    assign last_next = (m_d == M_MAX) && (n_d == N_MAX) && (k_d == K_MAX);

endmodule

`default_nettype wire

// File: rtl/tcu_uop_sequencer.sv
// ============================================================================
// Module   : tcu_uop_sequencer
// Brief    : Expands one TCU instruction into its ordered micro-op stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tcu_uop_sequencer
    import tcu_uop_sequencer_pkg::*;
#(
    parameter int M_STEPS = TCU_M_STEPS,
    parameter int N_STEPS = TCU_N_STEPS,
    parameter int K_STEPS = TCU_K_STEPS,
    parameter int RA      = TCU_RA,
    parameter int RB      = TCU_RB,
    parameter int RC      = TCU_RC,
    parameter int TAG_W   = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [1:0]                        in_op,
    input  logic [3:0]                        in_fmt_s,
    input  logic [3:0]                        in_fmt_d,
    input  logic [TAG_W-1:0]                  in_tag,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [1:0]                        out_op,
    output logic [3:0]                        out_fmt_s,
    output logic [3:0]                        out_fmt_d,
    output logic [TAG_W-1:0]                  out_tag,
    output logic [tcu_clog2_min1(M_STEPS)-1:0] out_step_m,
    output logic [tcu_clog2_min1(N_STEPS)-1:0] out_step_n,
    output logic [tcu_clog2_min1(K_STEPS)-1:0] out_step_k,
    output logic [4:0]                        out_ra,
    output logic [4:0]                        out_rb,
    output logic [4:0]                        out_rc,
    output logic                              out_meta_sel,
    output logic                              out_last,
    output logic                              err
);

    localparam int MW = tcu_clog2_min1(M_STEPS);
    localparam int NW = tcu_clog2_min1(N_STEPS);
    localparam int KW = tcu_clog2_min1(K_STEPS);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [1:0]         op_q, op_d;
    logic [3:0]         fmt_s_q, fmt_s_d;
    logic [3:0]         fmt_d_q, fmt_d_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [4:0]         ra_q, ra_d;
    logic [4:0]         rb_q, rb_d;
    logic [4:0]         rc_q, rc_d;
    logic               meta_q, meta_d;
    logic               last_q, last_d;
    logic               err_q, err_d;

    logic               cnt_clr, cnt_en, load;
    logic [1:0]         fop;
    logic [MW-1:0]      nxt_m;
    logic [NW-1:0]      nxt_n;
    logic [KW-1:0]      nxt_k;
    logic               cnt_last_next;
    logic [31:0]        ra_full, rb_full, rc_full;
    logic               meta_next;

    tcu_step_counter #(
        .M_STEPS (M_STEPS),
        .N_STEPS (N_STEPS),
        .K_STEPS (K_STEPS),
        .MW      (MW),
        .NW      (NW),
        .KW      (KW)
    ) u_step_counter (
        .clk       (clk),
        .reset     (reset),
        .clr       (cnt_clr),
        .en        (cnt_en),
        .step_m    (out_step_m),
        .step_n    (out_step_n),
        .step_k    (out_step_k),
        .next_m    (nxt_m),
        .next_n    (nxt_n),
        .next_k    (nxt_k),
        .last_next (cnt_last_next)
    );

    // Fields are built from the counter's next value so they land in flops
    // alongside the step indices.
    assign fop = (state_q == ST_IDLE) ? in_op : op_q;

    always_comb begin
        ra_full   = 32'(RA) + 32'(nxt_m) * 32'(K_STEPS) + 32'(nxt_k);
        rb_full   = 32'(RB) + 32'(nxt_n) * 32'(K_STEPS) + 32'(nxt_k);
        rc_full   = 32'(RC) + 32'(nxt_m) * 32'(N_STEPS) + 32'(nxt_n);
        meta_next = 1'b0;
        case (fop)
            TCU_OP_SP_WMMA: begin
                ra_full   = 32'(RA) + 32'(nxt_m) * 32'(K_STEPS / 2) + (32'(nxt_k) >> 1);
                meta_next = nxt_k[0];
            end
            TCU_OP_SP_MV_FORMAT: begin
                ra_full = 32'(RA);
                rb_full = 32'(RB);
                rc_full = 32'(RC);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        op_d        = op_q;
        fmt_s_d     = fmt_s_q;
        fmt_d_d     = fmt_d_q;
        tag_d       = tag_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        rc_d        = rc_q;
        meta_d      = meta_q;
        last_d      = last_q;
        err_d       = 1'b0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        load        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (in_op == TCU_OP_RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        op_d        = in_op;
                        fmt_s_d     = in_fmt_s;
                        fmt_d_d     = in_fmt_d;
                        tag_d       = in_tag;
                        cnt_clr     = 1'b1;
                        load        = 1'b1;
                        state_d     = ST_ISSUE;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (out_ready) begin
                    if (last_q) begin
                        state_d     = ST_IDLE;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                        last_d      = 1'b0;
                    end else begin
                        cnt_en = 1'b1;
                        load   = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            ra_d   = ra_full[4:0];
            rb_d   = rb_full[4:0];
            rc_d   = rc_full[4:0];
            meta_d = meta_next;
            last_d = (fop == TCU_OP_SP_MV_FORMAT) || cnt_last_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            op_q        <= '0;
            fmt_s_q     <= '0;
            fmt_d_q     <= '0;
            tag_q       <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            rc_q        <= '0;
            meta_q      <= 1'b0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            op_q        <= op_d;
            fmt_s_q     <= fmt_s_d;
            fmt_d_q     <= fmt_d_d;
            tag_q       <= tag_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            rc_q        <= rc_d;
            meta_q      <= meta_d;
            last_q      <= last_d;
            err_q       <= err_d;
        end
    end

    a_reg_index_range: assert property (@(posedge clk) disable iff (reset)
        load |-> (ra_full < 32 && rb_full < 32 && rc_full < 32));

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_op       = op_q;
    assign out_fmt_s    = fmt_s_q;
    assign out_fmt_d    = fmt_d_q;
    assign out_tag      = tag_q;
    assign out_ra       = ra_q;
    assign out_rb       = rb_q;
    assign out_rc       = rc_q;
    assign out_meta_sel = meta_q;
    assign out_last     = last_q;
    assign err          = err_q;

endmodule

`default_nettype wire

// File: tb/tb_tcu_uop_sequencer.sv
// ============================================================================
// Module   : tb_tcu_uop_sequencer
// Brief    : Self-checking bench for tcu_uop_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_tcu_uop_sequencer;
    import tcu_uop_sequencer_pkg::*;

    localparam int TAG_W  = 16;
    localparam int M      = 2;
    localparam int N      = 4;
    localparam int K      = 4;
    localparam int BUDGET = 400;

    logic             clk = 1'b0;
    logic             reset, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]       in_op, out_op;
    logic [3:0]       in_fmt_s, in_fmt_d, out_fmt_s, out_fmt_d;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic [0:0]       out_step_m;
    logic [1:0]       out_step_n, out_step_k;
    logic [4:0]       out_ra, out_rb, out_rc;
    logic             out_meta_sel, out_last, err;

    always #5 clk = ~clk;

    tcu_uop_sequencer #(.TAG_W(TAG_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_fmt_s     (in_fmt_s),
        .in_fmt_d     (in_fmt_d),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_op       (out_op),
        .out_fmt_s    (out_fmt_s),
        .out_fmt_d    (out_fmt_d),
        .out_tag      (out_tag),
        .out_step_m   (out_step_m),
        .out_step_n   (out_step_n),
        .out_step_k   (out_step_k),
        .out_ra       (out_ra),
        .out_rb       (out_rb),
        .out_rc       (out_rc),
        .out_meta_sel (out_meta_sel),
        .out_last     (out_last),
        .err          (err)
    );

    typedef struct {
        int k, m, n, ra, rb, rc;
        bit meta, last;
    } uop_rec_t;

    typedef struct {
        int op, idx;
        int k, m, n, ra, rb, rc;
        bit meta, last;
    } vec_t;

    int          n_cmp = 0;
    int          n_mis = 0;
    uop_rec_t    exp_q[$];
    logic [21:0] cap [0:2][0:63];
    vec_t        tbl [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [21:0] pack_uop(input int k, m, n, ra, rb, rc, input bit meta, last);
        return {1'(m), 2'(n), 2'(k), 5'(ra), 5'(rb), 5'(rc), meta, last};
    endfunction

    function automatic logic [21:0] dut_uop();
        return {out_step_m, out_step_n, out_step_k, out_ra, out_rb, out_rc, out_meta_sel, out_last};
    endfunction

    // Reference stream: direct enumeration of the loop nest and register map.
    task automatic build_model(input int op);
        uop_rec_t r;
        exp_q.delete();
        if (op == 2) begin
            r = '{0, 0, 0, 0, 8, 24, 1'b0, 1'b1};
            exp_q.push_back(r);
        end else begin
            for (int k = 0; k < K; k++)
                for (int m = 0; m < M; m++)
                    for (int n = 0; n < N; n++) begin
                        r.k    = k;
                        r.m    = m;
                        r.n    = n;
                        r.ra   = (op == 1) ? m * (K / 2) + k / 2 : m * K + k;
                        r.rb   = 8 + n * K + k;
                        r.rc   = 24 + m * N + n;
                        r.meta = (op == 1) ? bit'(k % 2) : 1'b0;
                        r.last = (k == K - 1) && (m == M - 1) && (n == N - 1);
                        exp_q.push_back(r);
                    end
        end
    endtask

    task automatic run_instr(input int op, input int ready_pct, input logic [3:0] fs, input logic [3:0] fd,
                             input logic [15:0] tag, input int stop_after, output int cycles);
        int       idx;
        bit       r;
        uop_rec_t e;
        logic [21:0] act;
        build_model(op);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_op    = 2'(op);
        in_fmt_s = fs;
        in_fmt_d = fd;
        in_tag   = tag;
        @(posedge clk); #1;
        in_valid = 1'b0;
        idx    = 0;
        cycles = 0;
        while (idx < exp_q.size() && idx != stop_after && cycles < BUDGET) begin
            e   = exp_q[idx];
            act = dut_uop();
            check("out_valid_busy", 64'(out_valid), 64'd1);
            check("in_ready_busy", 64'(in_ready), 64'd0);
            check("hdr", 64'({out_op, out_fmt_s, out_fmt_d, out_tag}), 64'({2'(op), fs, fd, tag}));
            check($sformatf("op%0d_uop%0d", op, idx), 64'(act),
                  64'(pack_uop(e.k, e.m, e.n, e.ra, e.rb, e.rc, e.meta, e.last)));
            r = ($urandom_range(99) < ready_pct);
            out_ready = r;
            if (r) cap[op][idx] = act;
            @(posedge clk); #1;
            cycles++;
            if (r) idx++;
        end
        out_ready = 1'b0;
        check("cycle_budget", 64'(cycles < BUDGET), 64'd1);
        if (stop_after < 0) begin
            check("handshakes", 64'(idx), 64'(exp_q.size()));
            check("out_valid_after", 64'(out_valid), 64'd0);
            check("in_ready_after", 64'(in_ready), 64'd1);
        end
    endtask

    initial begin
        int cyc;
        int op;

        tbl[0] = '{0, 0,  0, 0, 0, 0, 8,  24, 1'b0, 1'b0};
        tbl[1] = '{0, 1,  0, 0, 1, 0, 12, 25, 1'b0, 1'b0};
        tbl[2] = '{0, 5,  0, 1, 1, 4, 12, 29, 1'b0, 1'b0};
        tbl[3] = '{0, 8,  1, 0, 0, 1, 9,  24, 1'b0, 1'b0};
        tbl[4] = '{0, 31, 3, 1, 3, 7, 23, 31, 1'b0, 1'b1};
        tbl[5] = '{1, 28, 3, 1, 0, 3, 11, 28, 1'b1, 1'b0};
        tbl[6] = '{1, 16, 2, 0, 0, 1, 10, 24, 1'b0, 1'b0};
        tbl[7] = '{1, 31, 3, 1, 3, 3, 23, 31, 1'b1, 1'b1};
        tbl[8] = '{2, 0,  0, 0, 0, 0, 8,  24, 1'b0, 1'b1};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'd0;
        in_fmt_s  = 4'd0;
        in_fmt_d  = 4'd0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_fields", 64'(dut_uop()), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_instr(0, 100, 4'h3, 4'h5, 16'hBEEF, -1, cyc);
        check("wmma_cycles", 64'(cyc), 64'd32);
        @(posedge clk); #1;
        run_instr(1, 100, 4'h6, 4'h2, 16'h1234, -1, cyc);
        check("sp_wmma_cycles", 64'(cyc), 64'd32);
        run_instr(2, 100, 4'h9, 4'hA, 16'h00F0, -1, cyc);
        check("mv_cycles", 64'(cyc), 64'd1);

        for (int i = 0; i < 9; i++)
            check($sformatf("tbl%0d", i), 64'(cap[tbl[i].op][tbl[i].idx]),
                  64'(pack_uop(tbl[i].k, tbl[i].m, tbl[i].n, tbl[i].ra, tbl[i].rb, tbl[i].rc,
                               tbl[i].meta, tbl[i].last)));

        run_instr(0, 50, 4'h1, 4'h7, 16'hCAFE, -1, cyc);

        in_valid = 1'b1;
        in_op    = 2'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rsvd_err_pulse", 64'(err), 64'd1);
        check("rsvd_no_valid", 64'(out_valid), 64'd0);
        check("rsvd_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        check("rsvd_err_clear", 64'(err), 64'd0);
        check("rsvd_no_valid2", 64'(out_valid), 64'd0);

        run_instr(0, 100, 4'h2, 4'h3, 16'h0A0A, 10, cyc);
        reset     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        out_ready = 1'b0;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_last", 64'(out_last), 64'd0);
        @(posedge clk); #1;
        check("midrst_stay_idle", 64'(out_valid), 64'd0);
        run_instr(0, 100, 4'h2, 4'h3, 16'h0B0B, -1, cyc);

        reset    = 1'b1;
        in_valid = 1'b1;
        in_op    = 2'd0;
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        check("rst_vs_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("rst_vs_valid2", 64'(out_valid), 64'd0);
        check("rst_vs_valid_rdy", 64'(in_ready), 64'd1);

        for (int i = 0; i < 8; i++) begin
            op = $urandom_range(2);
            run_instr(op, 50, 4'($urandom), 4'($urandom), 16'($urandom), -1, cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tcu_uop_sequencer.md
# tcu_uop_sequencer

Expands one issued tensor-core instruction (WMMA, SP_WMMA, SP_MV_FORMAT) into the ordered stream of micro-ops consumed by the TCU execute stage. It sits directly upstream of the TCU functional unit. Per uop it emits the m/n/k step indices, the A/B/C register indices from the fixed TCU register map, and a last-uop marker. Only one instruction is in flight at a time.

## Interface
- M_STEPS, 2, tile M steps; equals TCU_M_STEPS
- N_STEPS, 4, tile N steps; equals TCU_N_STEPS
- K_STEPS, 4, tile K steps; equals TCU_K_STEPS
- RA / RB / RC, 0 / 8 / 24, register base indices for A, B, C
- TAG_W, 16, opaque instruction tag width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  instruction valid
- in_ready  out  1  sequencer can accept
- in_op  in  2  0=WMMA, 1=SP_WMMA, 2=SP_MV_FORMAT, 3=reserved
- in_fmt_s, in_fmt_d  in  4 each  source/dest format IDs, passed through
- in_tag  in  TAG_W  passed through
- out_valid  out  1  uop valid
- out_ready  in  1  TCU accepts uop
- out_op, out_fmt_s, out_fmt_d, out_tag  out  as inputs  registered copies
- out_step_m / out_step_n / out_step_k  out  clog2 of each STEPS (min 1)  step indices
- out_ra, out_rb, out_rc  out  5 each  register indices
- out_meta_sel  out  1  sparse metadata half select
- out_last  out  1  final uop of instruction
- err  out  1  one-cycle pulse on reserved op

## Operation
- States: IDLE, ISSUE.
- IDLE: in_ready=1. On in_valid: latch op/fmt/tag, clear counters k=m=n=0. Move to ISSUE, except op=3, which stays in IDLE, pulses err next cycle, and emits nothing.
- ISSUE: out_valid=1 and fields reflect the current counters. Advance only on out_valid&&out_ready.
- Loop order: n innermost, then m, then k outermost. Back-to-back uops never target the same C register unless M_STEPS*N_STEPS=1.
- UOP count: WMMA and SP_WMMA emit M_STEPS*N_STEPS*K_STEPS (default 32); SP_MV_FORMAT emits exactly one uop with all steps 0.
- Register map:
  - WMMA: ra=RA+m*K_STEPS+k; rb=RB+n*K_STEPS+k; rc=RC+m*N_STEPS+n; out_meta_sel=0.
  - SP_WMMA: ra=RA+m*(K_STEPS/2)+(k>>1); rb and rc as WMMA; out_meta_sel=k[0].
  - SP_MV_FORMAT: ra=RA, rb=RB, rc=RC.
  - Arithmetic is 5-bit unsigned. Parameters guarantee no overflow; assert in simulation that every index is below 32.
- out_last=1 on the uop where k=K_STEPS-1, m=M_STEPS-1, n=N_STEPS-1, and on the single SP_MV_FORMAT uop. Handshake on out_last returns the FSM to IDLE.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, out_last=0, err=0, all counters and register/step outputs 0.
- Latency: instruction accepted at edge t, first uop valid in the cycle after t. All outputs are registered.
- Throughput: 1 uop/cycle with out_ready held high. One IDLE bubble follows each instruction, so WMMA occupies 33 cycles.
- out_valid, once high, stays high with stable fields until accepted (no retraction).
- in_ready=0 throughout ISSUE, including the cycle of the last handshake.
- Counter wrap: n wraps to 0 and increments m; m wrap increments k. Wrap and handshake take effect in the same cycle.
- Reset mid-ISSUE: next cycle the FSM is in IDLE, out_valid=0, the partial instruction is dropped, and no out_last is emitted.
- Reset and in_valid in the same cycle: reset wins and the instruction is not accepted.

## Structure
- Op encodings (WMMA/SP_WMMA/SP_MV_FORMAT), step counts, and the RA/RB/RC bases come from the shared TCU package. The module parameters default to those package constants.
- Add a uop record typedef (steps, ra/rb/rc, meta_sel, last) to the same package for reuse by the execute stage.
- Natural sub-module: tcu_step_counter, a 3-level nested wrap counter with an enable, producing k/m/n and a last flag.

## Test plan
- WMMA, out_ready=1 -> 32 uops on consecutive cycles. First uop: ra=0, rb=8, rc=24. Uop 2: n=1, rb=12, rc=25. Final uop: k=3, m=1, n=3, ra=7, rb=23, rc=31, out_last=1. in_ready rises on the next cycle.
- SP_WMMA -> uop with k=3, m=1 gives ra=3, meta_sel=1; uop with k=2 gives ra=1 (m=0), meta_sel=0.
- SP_MV_FORMAT -> exactly one uop, steps 0, ra=0, rb=8, rc=24, out_last=1.
- Random out_ready stalls (about 50%) -> all fields stable while stalled, no uop duplicated or skipped, total 32 handshakes.
- reset asserted after 10 uops -> out_valid=0 next cycle, in_ready=1. A new WMMA then restarts at rc=24.
- in_op=3 -> err pulses once, no out_valid, in_ready stays 1.
